// File: rtl/vmail_ctrl_p_if.sv
// Keypad-to-message-store bundle: key strobe in, command levels, cursor/count and captured digits out.
interface vmail_ctrl_p_if #(
  parameter int KEY_W     = 4,
  parameter int MSG_SLOTS = 8
);
  localparam int SW = $clog2(MSG_SLOTS);
  localparam int CW = SW + 1;

  logic [KEY_W-1:0] key;
  logic             key_vld;
  logic             play;
  logic             recrd;
  logic             erase;
  logic             save;
  logic             address;
  logic [SW-1:0]    slot;
  logic [CW-1:0]    msg_count;
  logic             full;
  logic             empty;
  logic             dig_vld;
  logic [KEY_W-1:0] dig;
  logic [3:0]       dig_idx;
  logic             tmo;

  modport master (
    output key, key_vld,
    input  play, recrd, erase, save, address, slot, msg_count, full, empty,
           dig_vld, dig, dig_idx, tmo
  );

  modport slave (
    input  key, key_vld,
    output play, recrd, erase, save, address, slot, msg_count, full, empty,
           dig_vld, dig, dig_idx, tmo
  );
endinterface

// File: rtl/vmail_ctrl_p.sv
// Voice-mail key-press controller: keys change state on the sampling edge, Moore outputs follow one cycle later.
// No backpressure: every key_vld strobe is consumed (or ignored) in the cycle it arrives.
module vmail_ctrl_p #(
  parameter int KEY_W       = 4,
  parameter int ADDR_DIGITS = 3,
  parameter int MSG_SLOTS   = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          reset,
  vmail_ctrl_p_if.slave bus
);
  localparam int SW = $clog2(MSG_SLOTS);
  localparam int CW = SW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_MAIN, S_REVIEW, S_REPEAT, S_SAVE, S_ERASE, S_SEND,
    S_ADDRESS, S_RECORD, S_BEGIN_REC, S_MESSAGE
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    slot_q;
  logic [CW-1:0]    count_q;
  logic [TW-1:0]    idle_q;
  logic [3:0]       dig_cnt_q;
  logic             dig_vld_q, tmo_q;
  logic [KEY_W-1:0] dig_q;
  logic [3:0]       dig_idx_q;

  logic kv, k_one, k_two, k_three, k_five, k_star, k_pound, k_digit;
  logic empty_w, full_w, timeout_hit, cap, commit, slot_adv;

  assign kv      = bus.key_vld;
  assign k_one   = kv && (bus.key == KEY_W'(1));
  assign k_two   = kv && (bus.key == KEY_W'(2));
  assign k_three = kv && (bus.key == KEY_W'(3));
  assign k_five  = kv && (bus.key == KEY_W'(5));
  assign k_star  = kv && (bus.key == KEY_W'(10));
  assign k_pound = kv && (bus.key == KEY_W'(11));
  assign k_digit = kv && (bus.key <= KEY_W'(9));

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(MSG_SLOTS));
  // A key on the expiring edge wins, so the check requires an idle edge.
  assign timeout_hit = (state_q != S_MAIN) && !kv && (idle_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    cap      = 1'b0;
    commit   = 1'b0;
    slot_adv = 1'b0;
    if (timeout_hit) begin
      state_d = S_MAIN;
    end else begin
      case (state_q)
        S_MAIN: begin
          if (k_one)                state_d = S_REVIEW;
          else if (k_two && !full_w) state_d = S_SEND;
        end
        S_REVIEW: begin
          if (k_pound)                  state_d = S_MAIN;
          else if (!empty_w && k_one)   state_d = S_REPEAT;
          else if (!empty_w && k_two)   state_d = S_SAVE;
          else if (!empty_w && k_three) state_d = S_ERASE;
          else if (!empty_w && k_star)  slot_adv = 1'b1;
        end
        S_REPEAT, S_SAVE, S_ERASE: state_d = S_REVIEW;
        S_SEND:                    state_d = S_ADDRESS;
        S_ADDRESS: begin
          if (k_digit) begin
            cap = 1'b1;
            if (dig_cnt_q == 4'(ADDR_DIGITS - 1)) state_d = S_RECORD;
          end else if (k_pound && dig_cnt_q != 4'd0) begin
            state_d = S_RECORD;
          end
        end
        S_RECORD:    if (k_five) state_d = S_BEGIN_REC;
        S_BEGIN_REC: state_d = S_MESSAGE;
        S_MESSAGE: begin
          if (k_pound) begin
            commit  = 1'b1;
            state_d = S_MAIN;
          end
        end
        default:     state_d = S_MAIN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_MAIN;
      slot_q    <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      dig_cnt_q <= '0;
      dig_vld_q <= 1'b0;
      dig_q     <= '0;
      dig_idx_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= timeout_hit;
      dig_vld_q <= cap;
      idle_q    <= (kv || state_d == S_MAIN) ? '0 : idle_q + TW'(1);
      if (cap) begin
        dig_q     <= bus.key;
        dig_idx_q <= dig_cnt_q;
        dig_cnt_q <= dig_cnt_q + 4'd1;
      end else if (state_q == S_SEND) begin
        dig_cnt_q <= '0;
      end
      if (commit) count_q <= count_q + CW'(1);
      // Cursor stays below the count, so wrap is an equality test rather than a modulo.
      if (state_q == S_ERASE) begin
        count_q <= count_q - CW'(1);
        if (CW'(slot_q) >= count_q - CW'(1)) slot_q <= '0;
      end else if (slot_adv) begin
        slot_q <= (CW'(slot_q) + CW'(1) == count_q) ? '0 : slot_q + SW'(1);
      end
    end
  end

  assign bus.play      = (state_q == S_REPEAT);
  assign bus.save      = (state_q == S_SAVE);
  assign bus.erase     = (state_q == S_ERASE);
  assign bus.address   = (state_q == S_ADDRESS);
  assign bus.recrd     = (state_q == S_BEGIN_REC) || (state_q == S_MESSAGE);
  assign bus.slot      = slot_q;
  assign bus.msg_count = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.dig_vld   = dig_vld_q;
  assign bus.dig       = dig_q;
  assign bus.dig_idx   = dig_idx_q;
  assign bus.tmo       = tmo_q;
endmodule

// File: tb/tb_vmail_ctrl_p.sv
// Directed plus random key streams against a cycle-level reference model of the voice-mail controller.
module tb_vmail_ctrl_p;
  localparam int KEY_W = 4, ADDR_DIGITS = 3, MSG_SLOTS = 8, TIMEOUT = 255;
  localparam int M_MAIN = 0, M_REVIEW = 1, M_REPEAT = 2, M_SAVE = 3, M_ERASE = 4,
                 M_SEND = 5, M_ADDR = 6, M_RECORD = 7, M_BEGIN = 8, M_MSG = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  vmail_ctrl_p_if #(.KEY_W(KEY_W), .MSG_SLOTS(MSG_SLOTS)) bus ();

  vmail_ctrl_p #(.KEY_W(KEY_W), .ADDR_DIGITS(ADDR_DIGITS), .MSG_SLOTS(MSG_SLOTS),
                 .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: mode, stored count, cursor, digits taken, cycle of last activity.
  int m_mode, m_cnt, m_slot, m_digs, m_last, m_cyc;
  int m_dig_vld, m_dig, m_dig_idx, m_tmo;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int k);
    bit ke;
    m_cyc++;
    m_tmo = 0;
    m_dig_vld = 0;
    ke = v && (k <= 11);
    if (r) begin
      m_mode = M_MAIN; m_cnt = 0; m_slot = 0; m_digs = 0;
      m_dig = 0; m_dig_idx = 0; m_last = m_cyc;
      return;
    end
    if (!v && m_mode != M_MAIN && (m_cyc - m_last) == TIMEOUT) begin
      m_mode = M_MAIN;
      m_tmo = 1;
    end else begin
      case (m_mode)
        M_MAIN: if (ke && k == 1) m_mode = M_REVIEW;
                else if (ke && k == 2 && m_cnt < MSG_SLOTS) m_mode = M_SEND;
        M_REVIEW: if (ke) begin
          if (k == 11) m_mode = M_MAIN;
          else if (m_cnt > 0) begin
            if (k == 1) m_mode = M_REPEAT;
            else if (k == 2) m_mode = M_SAVE;
            else if (k == 3) m_mode = M_ERASE;
            else if (k == 10) m_slot = (m_slot + 1) % m_cnt;
          end
        end
        M_REPEAT, M_SAVE: m_mode = M_REVIEW;
        M_ERASE: begin
          m_cnt--;
          if (m_slot >= m_cnt) m_slot = 0;
          m_mode = M_REVIEW;
        end
        M_SEND: begin m_digs = 0; m_mode = M_ADDR; end
        M_ADDR: if (ke && k <= 9) begin
          m_dig_vld = 1; m_dig = k; m_dig_idx = m_digs; m_digs++;
          if (m_digs == ADDR_DIGITS) m_mode = M_RECORD;
        end else if (ke && k == 11 && m_digs >= 1) m_mode = M_RECORD;
        M_RECORD: if (ke && k == 5) m_mode = M_BEGIN;
        M_BEGIN:  m_mode = M_MSG;
        M_MSG: if (ke && k == 11) begin m_cnt++; m_mode = M_MAIN; end
        default: m_mode = M_MAIN;
      endcase
    end
    if (v || m_mode == M_MAIN) m_last = m_cyc;
  endtask

  task automatic compare_all();
    check("play", bus.play, m_mode == M_REPEAT);
    check("save", bus.save, m_mode == M_SAVE);
    check("erase", bus.erase, m_mode == M_ERASE);
    check("address", bus.address, m_mode == M_ADDR);
    check("recrd", bus.recrd, m_mode == M_BEGIN || m_mode == M_MSG);
    check("slot", bus.slot, m_slot);
    check("msg_count", bus.msg_count, m_cnt);
    check("full", bus.full, m_cnt == MSG_SLOTS);
    check("empty", bus.empty, m_cnt == 0);
    check("dig_vld", bus.dig_vld, m_dig_vld);
    check("tmo", bus.tmo, m_tmo);
    if (m_dig_vld != 0) begin
      check("dig", bus.dig, m_dig);
      check("dig_idx", bus.dig_idx, m_dig_idx);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int k);
    reset = r;
    bus.key_vld = v;
    bus.key = k[KEY_W-1:0];
    @(posedge clk);
    model_step(r, v, k);
    #1;
    compare_all();
  endtask

  task automatic press(input int k);
    cyc(1'b0, 1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
  endtask

  task automatic rec_msg();
    press(2); idle(1); press(1); press(11); press(5); idle(1); press(11);
  endtask

  initial begin
    bus.key = '0;
    bus.key_vld = 1'b0;
    m_mode = M_MAIN; m_cnt = 0; m_slot = 0; m_digs = 0; m_last = 0; m_cyc = 0;
    m_dig_vld = 0; m_dig = 0; m_dig_idx = 0; m_tmo = 0;
    cyc(1'b1, 1'b0, 0); cyc(1'b1, 1'b0, 0);
    check("rst_count", bus.msg_count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_slot", bus.slot, 0);

    // Full send: three digits, record, commit.
    press(2); idle(1); press(4); press(1); press(7); press(5); idle(1); press(11);
    check("t1_count", bus.msg_count, 1);
    check("t1_empty", bus.empty, 0);

    // Early pound after one digit, then pound with no digits is ignored.
    press(2); idle(1); press(9); press(11); press(5); idle(1); press(11);
    check("t2_count", bus.msg_count, 2);
    press(2); idle(1); press(11);
    check("t2_stay_addr", bus.address, 1);
    press(1); press(2); press(3);
    idle(TIMEOUT + 5);

    // Review cursor, erase, play.
    cyc(1'b1, 1'b0, 0);
    rec_msg(); rec_msg(); rec_msg();
    press(1);
    press(10); check("t3_slot1", bus.slot, 1);
    press(10); check("t3_slot2", bus.slot, 2);
    press(10); check("t3_slot0", bus.slot, 0);
    press(3);  check("t3_erase", bus.erase, 1);
    idle(1);   check("t3_count", bus.msg_count, 2);
    press(1);  check("t3_play", bus.play, 1);
    idle(1);   check("t3_play_end", bus.play, 0);
    press(11);

    // Fill to capacity; send gated.
    for (int i = 0; i < MSG_SLOTS - 2; i++) rec_msg();
    check("t4_full", bus.full, 1);
    press(2);
    check("t4_no_addr", bus.address, 0);

    // Inactivity timeout in MESSAGE; a late key keeps the session alive.
    cyc(1'b1, 1'b0, 0);
    press(2); idle(1); press(1); press(11); press(5); idle(1);
    idle(TIMEOUT - 2);
    check("t5_alive", bus.recrd, 1);
    press(3);
    idle(TIMEOUT - 1);
    check("t5_no_tmo", bus.tmo, 0);
    idle(1);
    check("t5_tmo", bus.tmo, 1);
    check("t5_count", bus.msg_count, 0);
    idle(1);
    check("t5_tmo_end", bus.tmo, 0);

    // Reset in the middle of a recording.
    for (int i = 0; i < 5; i++) rec_msg();
    press(2); idle(1); press(1); press(11); press(5); idle(1);
    check("t6_pre", bus.msg_count, 5);
    cyc(1'b1, 1'b0, 0);
    check("t6_recrd", bus.recrd, 0);
    check("t6_count", bus.msg_count, 0);
    check("t6_dig", bus.dig, 0);
    cyc(1'b0, 1'b0, 0);

    for (int i = 0; i < 4000; i++) begin
      int k;
      bit v, r;
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 11))
        0: k = 1;  1: k = 2;  2: k = 3;  3: k = 5;
        4: k = 10; 5: k = 11; default: k = $urandom_range(0, 15);
      endcase
      cyc(r, v, k);
      if (v && $urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
